// File: rtl/pipe_dmem_pkg.sv
// rtl/pipe_dmem_pkg.sv - shared types and default widths for the data-memory arbiter
package pipe_dmem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, BURST, DONE} dmaState_t;
  typedef enum logic [1:0] {NONE, CPU, DMA} owner_t;
endpackage

// File: rtl/pipe_dmem_dma_seq.sv
// rtl/pipe_dmem_dma_seq.sv - DMA burst sequencer: burst FSM, word address and remaining count
module pipe_dmem_dma_seq
  import pipe_dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmaStart,
  input  logic              dmaWe,
  input  logic [ADDR_W-1:0] dmaBase,
  input  logic [ADDR_W-1:0] dmaLen,
  input  logic              beat,
  output dmaState_t         state,
  output logic [ADDR_W-1:0] addr,
  output logic              burstWe
);
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] remaining;

  // Start pulses are only honoured in IDLE, so a running burst keeps its parameters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      burstWe   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dmaStart) begin
          addr      <= dmaBase;
          remaining <= dmaLen;
          burstWe   <= dmaWe;
          state     <= (dmaLen == '0) ? DONE : BURST;
        end
        BURST: if (beat) begin
          addr      <= addr + ONE;
          remaining <= remaining - ONE;
          if (remaining == ONE) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/pipe_dmem_arb.sv
// rtl/pipe_dmem_arb.sv - MEM-stage / DMA data-memory arbiter; PIPE_DMEM_ARB_FAIR_EN selects round-robin
module pipe_dmem_arb
  import pipe_dmem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_start,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [ADDR_W-1:0] dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_beat,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_dout
);
  dmaState_t         seqState;
  logic [ADDR_W-1:0] dmaAddr;
  logic              dmaDirWe;
  logic              inBurst;
  owner_t            owner;
  logic [ADDR_W-1:0] adrHold;
  logic [DATA_W-1:0] dinHold;

  assign inBurst = (seqState == BURST);

  pipe_dmem_dma_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .dmaStart (dma_start),
    .dmaWe    (dma_we),
    .dmaBase  (dma_base),
    .dmaLen   (dma_len),
    .beat     (dma_beat),
    .state    (seqState),
    .addr     (dmaAddr),
    .burstWe  (dmaDirWe)
  );

`ifdef PIPE_DMEM_ARB_FAIR_EN
  owner_t lastWinner;

  always_comb begin
    owner = NONE;
    if (inBurst) owner = (!cpu_req || lastWinner == CPU) ? DMA : CPU;
    else if (cpu_req) owner = CPU;
  end

  // Reset to DMA so the CPU takes the first contested slot.
  always_ff @(posedge clk) begin
    if (!rst_n) lastWinner <= DMA;
    else if (inBurst && owner != NONE) lastWinner <= owner;
  end
`else
  logic [3:0] starveCnt;

  always_comb begin
    owner = NONE;
    if (inBurst) owner = (!cpu_req || starveCnt == 4'(STARVE_MAX)) ? DMA : CPU;
    else if (cpu_req) owner = CPU;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starveCnt <= '0;
    else if (!inBurst || owner == DMA) starveCnt <= '0;
    else starveCnt <= starveCnt + 4'd1;
  end
`endif

  assign cpu_stall = cpu_req && (owner != CPU);
  assign dma_beat  = (owner == DMA);
  assign dma_busy  = (seqState != IDLE);
  assign dma_done  = (seqState == DONE);
  assign cpu_rdata = mem_dout;
  assign dma_rdata = mem_dout;

  // Address/data buses keep their last driven value when nobody owns memory.
  always_comb begin
    mem_adr = adrHold;
    mem_din = dinHold;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (owner)
      CPU: begin
        mem_adr = cpu_addr;
        mem_din = cpu_wdata;
        mem_we  = cpu_we;
        mem_re  = !cpu_we;
      end
      DMA: begin
        mem_adr = dmaAddr;
        mem_din = dma_wdata;
        mem_we  = dmaDirWe;
        mem_re  = !dmaDirWe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adrHold <= '0;
      dinHold <= '0;
    end else if (owner != NONE) begin
      adrHold <= mem_adr;
      dinHold <= mem_din;
    end
  end
endmodule

// File: tb/tb_pipe_dmem_arb.sv
// tb/tb_pipe_dmem_arb.sv - scoreboard bench for pipe_dmem_arb
module tb_pipe_dmem_arb;
  logic        clk = 1'b0;
  logic        rstN;
  logic        cpuReq, cpuWe, cpuStall;
  logic [9:0]  cpuAddr;
  logic [31:0] cpuWdata, cpuRdata;
  logic        dmaStart, dmaWe, dmaBeat, dmaBusy, dmaDone;
  logic [9:0]  dmaBase, dmaLen;
  logic [31:0] dmaWdata, dmaRdata;
  logic [9:0]  memAdr;
  logic [31:0] memDin, memDout;
  logic        memWe, memRe;

  always #5 clk = ~clk;

  assign memDout = 32'hC0DE0000 ^ {22'd0, memAdr};

  pipe_dmem_arb dut (
    .clk(clk), .rst_n(rstN),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_stall(cpuStall), .cpu_rdata(cpuRdata),
    .dma_start(dmaStart), .dma_we(dmaWe), .dma_base(dmaBase), .dma_len(dmaLen),
    .dma_wdata(dmaWdata), .dma_beat(dmaBeat), .dma_rdata(dmaRdata),
    .dma_busy(dmaBusy), .dma_done(dmaDone),
    .mem_adr(memAdr), .mem_din(memDin), .mem_we(memWe), .mem_re(memRe),
    .mem_dout(memDout)
  );

  typedef struct {
    string       nm;
    logic        st, bt, we, re, dn, by, ca;
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [31:0] pat(input logic [9:0] a);
    return 32'hC0DE0000 ^ {22'd0, a};
  endfunction

  // Monitor: one expected record per checked cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      logic ok;
      e  = expQ.pop_front();
      ok = (cpuStall == e.st) && (dmaBeat == e.bt) && (memWe == e.we) &&
           (memRe == e.re) && (dmaDone == e.dn) && (dmaBusy == e.by);
      if (e.we || e.re || e.ca) ok = ok && (memAdr == e.a);
      if (e.we || e.ca) ok = ok && (memDin == e.d);
      if (e.re) ok = ok && (cpuRdata == pat(e.a)) && (dmaRdata == pat(e.a));
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got stall=%b beat=%b we=%b re=%b done=%b busy=%b adr=%0d din=%h rdata=%h want stall=%b beat=%b we=%b re=%b done=%b busy=%b adr=%0d din=%h",
                    e.nm, cpuStall, dmaBeat, memWe, memRe, dmaDone, dmaBusy, memAdr, memDin, dmaRdata,
                    e.st, e.bt, e.we, e.re, e.dn, e.by, e.a, e.d);
    end
  end

  task automatic cyc(input string nm, input logic st, bt, we, re, dn, by, ca,
                     input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    e.nm = nm; e.st = st; e.bt = bt; e.we = we; e.re = re;
    e.dn = dn; e.by = by; e.ca = ca; e.a = a; e.d = d;
    expQ.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idleIn();
    cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0;
    dmaStart = 0; dmaWe = 0; dmaBase = '0; dmaLen = '0; dmaWdata = '0;
  endtask

  task automatic startDma(input logic we, input logic [9:0] base, input logic [9:0] len);
    dmaStart = 1; dmaWe = we; dmaBase = base; dmaLen = len;
  endtask

  initial begin
    idleIn();
    rstN = 0;
    repeat (2) @(posedge clk);
    #1 rstN = 1;

    cyc("reset_state", 0,0,0,0,0,0,1, 10'd0, 32'd0);

    cpuReq = 1; cpuWe = 1; cpuAddr = 10'd5; cpuWdata = 32'hDEADBEEF;
    cyc("cpu_write", 0,0,1,0,0,0,0, 10'd5, 32'hDEADBEEF);
    idleIn();
    cyc("bus_hold", 0,0,0,0,0,0,1, 10'd5, 32'hDEADBEEF);

    startDma(1, 10'd8, 10'd3);
    cyc("wr_start", 0,0,0,0,0,0,0, 10'd0, 32'd0);
    idleIn();
    for (int i = 0; i < 3; i++) begin
      dmaWdata = 32'h100 + i;
      cyc("wr_beat", 0,1,1,0,0,1,0, 10'(8 + i), 32'h100 + i);
    end
    idleIn();
    cyc("wr_done", 0,0,0,0,1,1,0, 10'd0, 32'd0);
    cyc("wr_idle", 0,0,0,0,0,0,0, 10'd0, 32'd0);

    startDma(0, 10'd20, 10'd2);
    cpuReq = 1; cpuWe = 0; cpuAddr = 10'd3;
    cyc("rd_start_cpu", 0,0,0,1,0,0,0, 10'd3, 32'd0);
    dmaStart = 0;
`ifdef PIPE_DMEM_ARB_FAIR_EN
    for (int i = 1; i <= 4; i++) begin
      if (i % 2 == 0) cyc("fair_dma", 1,1,0,1,0,1,0, 10'(20 + i/2 - 1), 32'd0);
      else            cyc("fair_cpu", 0,0,0,1,0,1,0, 10'd3, 32'd0);
    end
`else
    for (int i = 1; i <= 10; i++) begin
      if (i % 5 == 0) cyc("starve_dma", 1,1,0,1,0,1,0, 10'(20 + i/5 - 1), 32'd0);
      else            cyc("starve_cpu", 0,0,0,1,0,1,0, 10'd3, 32'd0);
    end
`endif
    cyc("rd_done_cpu", 0,0,0,1,1,1,0, 10'd3, 32'd0);
    idleIn();
    cyc("rd_idle", 0,0,0,0,0,0,0, 10'd0, 32'd0);

    startDma(1, 10'd1023, 10'd2);
    cyc("wrap_start", 0,0,0,0,0,0,0, 10'd0, 32'd0);
    idleIn();
    dmaWdata = 32'hAAAA0001;
    cyc("wrap_beat_hi", 0,1,1,0,0,1,0, 10'd1023, 32'hAAAA0001);
    dmaWdata = 32'hAAAA0002;
    cyc("wrap_beat_lo", 0,1,1,0,0,1,0, 10'd0, 32'hAAAA0002);
    idleIn();
    cyc("wrap_done", 0,0,0,0,1,1,0, 10'd0, 32'd0);

    startDma(1, 10'd30, 10'd0);
    cyc("len0_start", 0,0,0,0,0,0,0, 10'd0, 32'd0);
    idleIn();
    cyc("len0_done", 0,0,0,0,1,1,0, 10'd0, 32'd0);
    cyc("len0_idle", 0,0,0,0,0,0,0, 10'd0, 32'd0);

    startDma(1, 10'd40, 10'd2);
    cyc("ign_start", 0,0,0,0,0,0,0, 10'd0, 32'd0);
    startDma(1, 10'd100, 10'd5);
    dmaWdata = 32'h40;
    cyc("ign_beat0", 0,1,1,0,0,1,0, 10'd40, 32'h40);
    idleIn();
    dmaWdata = 32'h41;
    cyc("ign_beat1", 0,1,1,0,0,1,0, 10'd41, 32'h41);
    idleIn();
    cyc("ign_done", 0,0,0,0,1,1,0, 10'd0, 32'd0);
    cyc("ign_idle", 0,0,0,0,0,0,0, 10'd0, 32'd0);

    startDma(1, 10'd50, 10'd4);
    cyc("abort_start", 0,0,0,0,0,0,0, 10'd0, 32'd0);
    idleIn();
    dmaWdata = 32'h50;
    cyc("abort_beat", 0,1,1,0,0,1,0, 10'd50, 32'h50);
    rstN = 0;
    @(posedge clk); #1;
    rstN = 1;
    cyc("abort_idle", 0,0,0,0,0,0,1, 10'd0, 32'd0);
    cyc("abort_nodone", 0,0,0,0,0,0,0, 10'd0, 32'd0);

    for (int n = 0; n < 20 && expQ.size() > 0; n++) @(posedge clk);
    if (expQ.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d records left, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
